bin_pack_stream: RTL and testbench

//  Sink for the 1-bit binarised pixel stream (sop/eop/vld + 1-bit pixel).

---
 rtl/bin_pack_stream_if.sv | 28 ++
 rtl/bin_pack_stream.sv | 207 ++++++++++++++++++++
 tb/tb_bin_pack_stream.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/bin_pack_stream_if.sv
// Stream bundle for the binary pixel packer.
// It carries the 1-bit pixel input side and the packed word output side.
interface bin_pack_stream_if #(
    parameter int DW = 16
);
    localparam int CW = $clog2(DW) + 1;

    logic          i_din_sop;
    logic          i_din_eop;
    logic          i_din_vld;
    logic          i_din;
    logic          o_dout_sop;
    logic          o_dout_eop;
    logic          o_dout_vld;
    logic [DW-1:0] o_dout;
    logic [CW-1:0] o_dout_cnt;
    logic          o_frame_err;

    modport master (
        output i_din_sop, i_din_eop, i_din_vld, i_din,
        input  o_dout_sop, o_dout_eop, o_dout_vld, o_dout, o_dout_cnt, o_frame_err
    );

    modport slave (
        input  i_din_sop, i_din_eop, i_din_vld, i_din,
        output o_dout_sop, o_dout_eop, o_dout_vld, o_dout, o_dout_cnt, o_frame_err
    );
endinterface

// File: rtl/bin_pack_stream.sv
// Packs a 1-bit binarised pixel stream into DW-bit words.
// Frame markers are carried through, and a truncated frame is flushed with an error pulse.
module bin_pack_stream #(
    parameter int DW        = 16,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    bin_pack_stream_if.slave bus
);
    localparam int            CW   = $clog2(DW) + 1;
    localparam logic [CW-1:0] FULL = CW'(DW);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic {IDLE, FRAME} state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [DW-1:0] r_shift;
    logic [CW-1:0] r_cnt;
    logic          r_pend_sop;
    logic          r_hold_vld;
    logic          r_hold_pix;

    logic [DW-1:0] r_dout;
    logic          r_dout_sop;
    logic          r_dout_eop;
    logic          r_dout_vld;
    logic [CW-1:0] r_dout_cnt;
    logic          r_frame_err;

    logic          w_vld;
    logic          w_sop;
    logic          w_eop;
    logic          w_pix;
    logic [CW-1:0] w_cnt_inc;
    logic [DW-1:0] w_word_acc;

    logic          w_emit;
    logic [DW-1:0] w_word;
    logic          w_word_sop;
    logic          w_word_eop;
    logic [CW-1:0] w_word_cnt;
    logic          w_err;
    logic [DW-1:0] w_shift_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_pend_nxt;
    logic          w_hold_vld_nxt;
    logic          w_hold_pix_nxt;

    function automatic logic [DW-1:0] placePixel(input logic pix, input logic [CW-1:0] idx);
        logic [DW-1:0] v;
        v = '0;
        for (int i = 0; i < DW; i++) begin
            if (MSB_FIRST ? (i == DW - 1 - int'(idx)) : (i == int'(idx))) begin
                v[i] = pix;
            end
        end
        return v;
    endfunction

    assign w_vld      = bus.i_din_vld;
    assign w_sop      = bus.i_din_sop;
    assign w_eop      = bus.i_din_eop;
    assign w_pix      = bus.i_din;
    assign w_cnt_inc  = r_cnt + ONE;
    assign w_word_acc = r_shift | placePixel(w_pix, r_cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_vld && w_sop && !w_eop) w_state_nxt = FRAME;
            FRAME:   if (w_vld && w_eop) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // A sop&eop beat that arrives mid-frame yields two words in one cycle; the
    // one-pixel word waits in the hold slot and goes out on the following clock.
    always_comb begin
        w_emit         = 1'b0;
        w_word         = r_shift;
        w_word_sop     = r_pend_sop;
        w_word_eop     = 1'b0;
        w_word_cnt     = r_cnt;
        w_err          = 1'b0;
        w_shift_nxt    = r_shift;
        w_cnt_nxt      = r_cnt;
        w_pend_nxt     = r_pend_sop;
        w_hold_vld_nxt = 1'b0;
        w_hold_pix_nxt = r_hold_pix;
        case (r_state)
            IDLE: begin
                if (r_hold_vld) begin
                    w_emit     = 1'b1;
                    w_word     = placePixel(r_hold_pix, '0);
                    w_word_sop = 1'b1;
                    w_word_eop = 1'b1;
                    w_word_cnt = ONE;
                end
                if (w_vld && w_sop) begin
                    if (w_eop) begin
                        if (r_hold_vld) begin
                            w_hold_vld_nxt = 1'b1;
                            w_hold_pix_nxt = w_pix;
                        end else begin
                            w_emit     = 1'b1;
                            w_word     = placePixel(w_pix, '0);
                            w_word_sop = 1'b1;
                            w_word_eop = 1'b1;
                            w_word_cnt = ONE;
                        end
                    end else begin
                        w_shift_nxt = placePixel(w_pix, '0);
                        w_cnt_nxt   = ONE;
                        w_pend_nxt  = 1'b1;
                    end
                end else if (w_vld) begin
                    w_err = 1'b1;
                end
            end
            FRAME: begin
                if (w_vld && w_sop) begin
                    w_emit     = 1'b1;
                    w_word_eop = 1'b1;
                    w_err      = 1'b1;
                    if (w_eop) begin
                        w_hold_vld_nxt = 1'b1;
                        w_hold_pix_nxt = w_pix;
                        w_shift_nxt    = '0;
                        w_cnt_nxt      = '0;
                        w_pend_nxt     = 1'b0;
                    end else begin
                        w_shift_nxt = placePixel(w_pix, '0);
                        w_cnt_nxt   = ONE;
                        w_pend_nxt  = 1'b1;
                    end
                end else if (w_vld) begin
                    if (w_cnt_inc == FULL || w_eop) begin
                        w_emit      = 1'b1;
                        w_word      = w_word_acc;
                        w_word_eop  = w_eop;
                        w_word_cnt  = w_cnt_inc;
                        w_shift_nxt = '0;
                        w_cnt_nxt   = '0;
                        w_pend_nxt  = 1'b0;
                    end else begin
                        w_shift_nxt = w_word_acc;
                        w_cnt_nxt   = w_cnt_inc;
                    end
                end
            end
            default: begin
                w_shift_nxt = '0;
                w_cnt_nxt   = '0;
                w_pend_nxt  = 1'b0;
            end
        endcase
    end

    // Word fields keep their last value between emits; only vld and err pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift     <= '0;
            r_cnt       <= '0;
            r_pend_sop  <= 1'b0;
            r_hold_vld  <= 1'b0;
            r_hold_pix  <= 1'b0;
            r_dout      <= '0;
            r_dout_sop  <= 1'b0;
            r_dout_eop  <= 1'b0;
            r_dout_vld  <= 1'b0;
            r_dout_cnt  <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_shift     <= w_shift_nxt;
            r_cnt       <= w_cnt_nxt;
            r_pend_sop  <= w_pend_nxt;
            r_hold_vld  <= w_hold_vld_nxt;
            r_hold_pix  <= w_hold_pix_nxt;
            r_dout_vld  <= w_emit;
            r_frame_err <= w_err;
            if (w_emit) begin
                r_dout     <= w_word;
                r_dout_sop <= w_word_sop;
                r_dout_eop <= w_word_eop;
                r_dout_cnt <= w_word_cnt;
            end
        end
    end

    assign bus.o_dout      = r_dout;
    assign bus.o_dout_sop  = r_dout_sop;
    assign bus.o_dout_eop  = r_dout_eop;
    assign bus.o_dout_vld  = r_dout_vld;
    assign bus.o_dout_cnt  = r_dout_cnt;
    assign bus.o_frame_err = r_frame_err;
endmodule

// File: tb/tb_bin_pack_stream.sv
// Self-checking bench for bin_pack_stream: directed frames followed by random traffic,
// compared every cycle against a queue-based model of the packing and framing rules.
module tb_bin_pack_stream;
    localparam int DW        = 16;
    localparam bit MSB_FIRST = 1'b0;
    localparam int CW        = $clog2(DW) + 1;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        logic [CW-1:0] cnt;
    } word_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    bin_pack_stream_if #(.DW(DW)) busIf ();

    bin_pack_stream #(.DW(DW), .MSB_FIRST(MSB_FIRST)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busIf.slave)
    );

    always #5 clk = ~clk;

    int    checks   = 0;
    int    failures = 0;
    int    obsWords = 0;
    int    obsErrs  = 0;

    word_t wordQ[$];
    word_t lastWord;
    bit    cur[$];
    bit    inFrame;
    bit    pend;
    bit    expErr;
    bit    expVld;

    // Packs the pixels collected so far into one word, pixel k at its packing position.
    function automatic word_t makeWord(input bit s, input bit e);
        word_t w;
        w.data = '0;
        for (int k = 0; k < cur.size(); k++) begin
            w.data[MSB_FIRST ? (DW - 1 - k) : k] = cur[k];
        end
        w.sop = s;
        w.eop = e;
        w.cnt = CW'(cur.size());
        return w;
    endfunction

    task automatic modelReset();
        wordQ.delete();
        cur.delete();
        inFrame  = 1'b0;
        pend     = 1'b0;
        lastWord = '0;
        expErr   = 1'b0;
        expVld   = 1'b0;
    endtask

    // Words are queued as the rules produce them; the DUT delivers at most one per clock.
    task automatic modelBeat(input bit s, input bit e, input bit v, input bit p);
        expErr = 1'b0;
        if (v) begin
            if (inFrame && s) begin
                wordQ.push_back(makeWord(pend, 1'b1));
                expErr  = 1'b1;
                cur.delete();
                pend    = 1'b0;
                inFrame = 1'b0;
            end
            if (!inFrame) begin
                if (s) begin
                    cur.delete();
                    cur.push_back(p);
                    if (e) begin
                        wordQ.push_back(makeWord(1'b1, 1'b1));
                        cur.delete();
                    end else begin
                        pend    = 1'b1;
                        inFrame = 1'b1;
                    end
                end else begin
                    expErr = 1'b1;
                end
            end else begin
                cur.push_back(p);
                if (cur.size() == DW || e) begin
                    wordQ.push_back(makeWord(pend, e));
                    cur.delete();
                    pend = 1'b0;
                    if (e) inFrame = 1'b0;
                end
            end
        end
        expVld = 1'b0;
        if (wordQ.size() > 0) begin
            lastWord = wordQ.pop_front();
            expVld   = 1'b1;
        end
    endtask

    task automatic checkField(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit s, input bit e, input bit v, input bit p);
        busIf.i_din_sop = s;
        busIf.i_din_eop = e;
        busIf.i_din_vld = v;
        busIf.i_din     = p;
        modelBeat(s, e, v, p);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag);
        if (busIf.o_dout_vld === 1'b1) obsWords++;
        if (busIf.o_frame_err === 1'b1) obsErrs++;
        checkField({tag, ".vld"}, 32'(busIf.o_dout_vld),  32'(expVld));
        checkField({tag, ".err"}, 32'(busIf.o_frame_err), 32'(expErr));
        checkField({tag, ".sop"}, 32'(busIf.o_dout_sop),  32'(lastWord.sop));
        checkField({tag, ".eop"}, 32'(busIf.o_dout_eop),  32'(lastWord.eop));
        checkField({tag, ".cnt"}, 32'(busIf.o_dout_cnt),  32'(lastWord.cnt));
        checkField({tag, ".dout"}, 32'(busIf.o_dout),     32'(lastWord.data));
    endtask

    task automatic beat(input string tag, input bit s, input bit e, input bit v, input bit p);
        applyStimulus(s, e, v, p);
        checkOutput(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) beat(tag, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic startTest(input string name);
        obsWords = 0;
        obsErrs  = 0;
        $display("[TB] %s", name);
    endtask

    initial begin
        busIf.i_din_sop = 1'b0;
        busIf.i_din_eop = 1'b0;
        busIf.i_din_vld = 1'b0;
        busIf.i_din     = 1'b0;
        modelReset();
        @(negedge clk);
        checkOutput("reset");
        rst_n = 1'b1;

        startTest("alternating 32-pixel frame");
        for (int i = 0; i < 32; i++) beat("t1", i == 0, i == 31, 1'b1, ~i[0]);
        idle("t1", 2);
        checkField("t1.words", 32'(obsWords), 32'd2);

        startTest("20-pixel frame of ones");
        for (int i = 0; i < 20; i++) beat("t2", i == 0, i == 19, 1'b1, 1'b1);
        idle("t2", 2);
        checkField("t2.words", 32'(obsWords), 32'd2);
        checkField("t2.errs", 32'(obsErrs), 32'd0);

        startTest("single sop&eop beat");
        beat("t3", 1'b1, 1'b1, 1'b1, 1'b1);
        idle("t3", 2);
        checkField("t3.words", 32'(obsWords), 32'd1);

        startTest("truncated frame then new frame");
        for (int i = 0; i < 5; i++) beat("t4", i == 0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 16; i++) beat("t4", i == 0, i == 15, 1'b1, i[1]);
        idle("t4", 2);
        checkField("t4.words", 32'(obsWords), 32'd2);
        checkField("t4.errs", 32'(obsErrs), 32'd1);

        startTest("beats without sop while idle");
        for (int i = 0; i < 3; i++) beat("t5", 1'b0, 1'b0, 1'b1, 1'b1);
        idle("t5", 2);
        checkField("t5.words", 32'(obsWords), 32'd0);
        checkField("t5.errs", 32'(obsErrs), 32'd3);

        startTest("reset mid-frame, then gapped frames");
        for (int i = 0; i < 7; i++) beat("t6", i == 0, 1'b0, 1'b1, 1'b1);
        rst_n = 1'b0;
        busIf.i_din_vld = 1'b0;
        modelReset();
        @(negedge clk);
        checkOutput("t6.rst");
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) beat("t6", i == 0, i == 15, 1'b1, i[0] ^ i[2]);
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 1) == 1) beat("t6g", 1'b0, 1'b0, 1'b0, 1'b1);
            beat("t6g", i == 0, i == 15, 1'b1, i[0] ^ i[2]);
        end
        idle("t6", 2);
        checkField("t6.words", 32'(obsWords), 32'd2);

        startTest("sop&eop interrupting a frame");
        for (int i = 0; i < 4; i++) beat("t7", i == 0, 1'b0, 1'b1, 1'b1);
        beat("t7", 1'b1, 1'b1, 1'b1, 1'b1);
        beat("t7", 1'b1, 1'b1, 1'b1, 1'b0);
        idle("t7", 3);
        checkField("t7.words", 32'(obsWords), 32'd3);
        checkField("t7.errs", 32'(obsErrs), 32'd1);

        startTest("random traffic");
        for (int f = 0; f < 200; f++) begin
            int  kind;
            int  n;
            bit  trunc;
            kind = int'($urandom_range(0, 9));
            if (kind == 0) begin
                beat("rnd", 1'b0, 1'(($urandom)), 1'b1, 1'(($urandom)));
            end else if (kind == 1) begin
                beat("rnd", 1'b1, 1'b1, 1'b1, 1'(($urandom)));
            end else begin
                n     = int'($urandom_range(1, 40));
                trunc = (kind == 2);
                for (int i = 0; i < n; i++) begin
                    if ($urandom_range(0, 3) == 0)
                        beat("rnd", 1'(($urandom)), 1'(($urandom)), 1'b0, 1'(($urandom)));
                    beat("rnd", i == 0, (i == n - 1) && !trunc, 1'b1, 1'(($urandom)));
                end
            end
        end
        idle("rnd", 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
